fcb_bs_loader: RTL and testbench
================================

FCB_BS_LOADER -- requirements
Module: fcb_bs_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of bitstream word entries; it SHALL be a power of 2 and at least 2.
REQ-002 SHALL have parameter BS_ADDR, default 32'h0000_0040, meaning the FCB bitstream-data register address driven on every write.
REQ-003 SHALL have port fcb_clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port fcb_rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port bs_valid_i, input, 1 bit: the source has a bitstream word.
REQ-006 SHALL have port bs_data_i, input, 32 bits: the bitstream word.
REQ-007 SHALL have port bs_last_i, input, 1 bit: the word is the final word of the frame.
REQ-008 SHALL have port bs_ready_o, output, 1 bit: the block accepts a word this cycle.
REQ-009 SHALL have port fcb_apbm_paddr_o, output, 32 bits: APB address to fcb_apbs_paddr_i.
REQ-010 SHALL have ports fcb_apbm_psel_o, fcb_apbm_penable_o and fcb_apbm_pwrite_o, outputs, 1 bit each: APB controls.
REQ-011 SHALL have port fcb_apbm_pwdata_o, output, 32 bits: APB write data.
REQ-012 SHALL have ports fcb_apbm_pready_i and fcb_apbm_pslverr_i, inputs, 1 bit each: the APB completion response.
REQ-013 SHALL have ports busy_o, done_o and err_o, outputs, 1 bit each: frame in progress; 1-cycle end-of-frame pulse; sticky error.
REQ-014 SHALL have port err_clr_i, input, 1 bit: synchronous clear of err_o.
REQ-015 SHALL have port word_cnt_o, output, 16 bits: count of successful writes in the current or last frame.

Function
REQ-016 A word SHALL be accepted when bs_valid_i and bs_ready_o are both high; bs_ready_o SHALL equal !fifo_full, except in ERR where it is 1.
REQ-017 The FIFO SHALL store {last, data}; a push is accepted at full only if a pop registered in an earlier cycle has freed space; a pop in the same cycle as full does not enable a push.
REQ-018 The FSM SHALL have states IDLE, SETUP, ACCESS and ERR.
REQ-019 In IDLE with the FIFO non-empty, the next state SHALL be SETUP.
REQ-020 SETUP SHALL drive psel=1, penable=0, pwrite=1, paddr=BS_ADDR and pwdata=FIFO head, then go to ACCESS unconditionally.
REQ-021 ACCESS SHALL drive psel=1 and penable=1, holding paddr and pwdata stable until fcb_apbm_pready_i is high.
REQ-022 On pready in ACCESS, the FSM SHALL pop the head entry.
REQ-023 On pready with pslverr=1, the FSM SHALL go to ERR and set err_o; word_cnt_o SHALL not increment.
REQ-024 On pready with pslverr=0, word_cnt_o SHALL increment, saturating at 16'hFFFF.
REQ-025 After a successful pop of a last-flagged entry, done_o SHALL pulse for 1 cycle and the FSM SHALL go to IDLE.
REQ-026 After a successful pop of any other entry, the FSM SHALL go to SETUP if the FIFO is non-empty, else to IDLE.
REQ-027 Latency: a word accepted at cycle N into an empty FIFO in IDLE SHALL produce psel at N+1 and penable at N+2; a zero-wait transfer completes at N+2.
REQ-028 Back-to-back words SHALL sustain 1 write per 2 cycles.
REQ-029 In IDLE, psel and penable SHALL be 0.
REQ-030 ERR SHALL flush the FIFO and discard accepted words until a word with bs_last_i=1 is accepted (or a last-flagged entry is found in the flushed FIFO), then go to IDLE; done_o SHALL not pulse.
REQ-031 busy_o SHALL be 1 when the state is not IDLE or the FIFO is non-empty.
REQ-032 word_cnt_o SHALL clear to 0 on the first word accepted after done_o or after leaving ERR.
REQ-033 err_o SHALL stay set until err_clr_i; if err_clr_i and a new error occur in the same cycle, set SHALL win.

Reset
REQ-034 On fcb_rst_ni=0, the block SHALL immediately empty the FIFO, go to IDLE, and zero all outputs, including paddr, pwdata and word_cnt_o; bs_ready_o SHALL be 0 during reset.
REQ-035 Reset asserted mid-transfer SHALL drop psel combinationally, with no completion and no done_o after release.
REQ-036 Reset release SHALL be used directly; it is synchronized upstream.

Configuration
REQ-037 With macro FCB_BS_LOADER_TIMEOUT_EN defined, an 8-bit wait counter SHALL count ACCESS cycles without pready; on reaching 255 the FSM SHALL drop psel/penable, set err_o and enter ERR.
REQ-038 Without FCB_BS_LOADER_TIMEOUT_EN, ACCESS SHALL wait indefinitely and the counter logic SHALL be absent.

Verification
REQ-039 Push 3 words (last on the third) with pready tied to 1 -> 3 writes to 32'h0000_0040 in 6 cycles, word_cnt_o=3, done_o pulses once.
REQ-040 Stream 8 words with pready low for 3 cycles per transfer -> bs_ready_o=0 while 4 words are queued, no word lost or reordered, word_cnt_o=8.
REQ-041 Assert pslverr on word 2 of a 5-word frame -> err_o=1, word_cnt_o=1, words 3-5 discarded, no done_o, IDLE afterwards.
REQ-042 Assert fcb_rst_ni=0 during ACCESS -> psel=0 immediately, all outputs 0; after release, a new 1-word frame completes normally.
REQ-043 With FCB_BS_LOADER_TIMEOUT_EN defined and pready held 0 -> psel drops after 255 ACCESS cycles, err_o=1.
REQ-044 Pulse err_clr_i with an error on the same cycle -> err_o remains 1.

Source files
------------

// File: rtl/fcb_bs_loader.sv
// fcb_bs_loader: bitstream word loader for the FCB.
// Words from a valid/ready source are queued in a small FIFO.
// Each queued word is written to a fixed FCB register address through an APB master.
// A slave error discards the rest of the frame and sets a sticky error flag.
// Optional feature: define FCB_BS_LOADER_TIMEOUT_EN to abort an ACCESS phase after
// 255 cycles without pready.
module fcb_bs_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BS_ADDR    = 32'h0000_0040
) (
  input  logic        fcb_clk_i,
  input  logic        fcb_rst_ni,
  input  logic        bs_valid_i,
  input  logic [31:0] bs_data_i,
  input  logic        bs_last_i,
  output logic        bs_ready_o,
  output logic [31:0] fcb_apbm_paddr_o,
  output logic        fcb_apbm_psel_o,
  output logic        fcb_apbm_penable_o,
  output logic        fcb_apbm_pwrite_o,
  output logic [31:0] fcb_apbm_pwdata_o,
  input  logic        fcb_apbm_pready_i,
  input  logic        fcb_apbm_pslverr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [15:0] word_cnt_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  // FIFO storage: bit 32 is the last-of-frame flag, bits 31:0 the word.
  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [32:0]   head;
  logic          fifo_full, fifo_empty, fifo_has_last;

  logic push, pop, pop_ok, flush;
  logic err_set, done_set, leave_err;
  logic err_last_q, err_last_d;
  logic cnt_clr_pend_q;
  logic apb_active;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);

  // In ERR the source is drained so the rest of a failed frame can be discarded.
  assign bs_ready_o = fcb_rst_ni & ((state_q == S_ERR) | ~fifo_full);
  assign push       = bs_valid_i & bs_ready_o & (state_q != S_ERR);
  assign pop_ok     = pop & ~fcb_apbm_pslverr_i;
  assign busy_o     = (state_q != S_IDLE) | ~fifo_empty;

`ifdef FCB_BS_LOADER_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  // Count consecutive ACCESS cycles that have not seen pready.
  always_ff @(posedge fcb_clk_i or negedge fcb_rst_ni) begin
    if (!fcb_rst_ni) begin
      wait_cnt_q <= '0;
    end else if ((state_q == S_ACCESS) && !fcb_apbm_pready_i) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_q <= '0;
    end
  end
`endif

  // Look for a last-flagged entry among the occupied FIFO slots.
  always_comb begin
    fifo_has_last = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CW'(i) < cnt_q) && mem_q[rd_ptr_q + AW'(i)][32]) begin
        fifo_has_last = 1'b1;
      end
    end
  end

  // FSM next state and transfer/status events.
  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    flush      = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    leave_err  = 1'b0;
    err_last_d = err_last_q;
    apb_active = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Include this cycle's push so a word reaches the bus one cycle after acceptance.
        if (!fifo_empty || push) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        apb_active = 1'b1;
        state_d    = S_ACCESS;
      end
      S_ACCESS: begin
        apb_active = 1'b1;
        if (fcb_apbm_pready_i) begin
          pop = 1'b1;
          if (fcb_apbm_pslverr_i) begin
            state_d    = S_ERR;
            err_set    = 1'b1;
            // A failed last word already ends the frame, so ERR must not wait for another.
            err_last_d = head[32];
          end else if (head[32]) begin
            state_d  = S_IDLE;
            done_set = 1'b1;
          end else if ((cnt_q > CNT_ONE) || push) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
`ifdef FCB_BS_LOADER_TIMEOUT_EN
        // 254 earlier misses plus this one make 255 ACCESS cycles without pready.
        else if (wait_cnt_q == 8'd254) begin
          state_d    = S_ERR;
          err_set    = 1'b1;
          err_last_d = 1'b0;
        end
`endif
      end
      S_ERR: begin
        flush = 1'b1;
        if (fifo_has_last || err_last_q || (bs_valid_i && bs_ready_o && bs_last_i)) begin
          state_d   = S_IDLE;
          leave_err = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // APB outputs are decoded from state only, so reset clears them at once.
  always_comb begin
    fcb_apbm_psel_o    = apb_active;
    fcb_apbm_penable_o = (state_q == S_ACCESS);
    fcb_apbm_pwrite_o  = apb_active;
    fcb_apbm_paddr_o   = apb_active ? BS_ADDR : '0;
    fcb_apbm_pwdata_o  = apb_active ? head[31:0] : '0;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge fcb_clk_i or negedge fcb_rst_ni) begin
    if (!fcb_rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO pointers and occupancy; ERR empties the queue in one cycle.
  always_ff @(posedge fcb_clk_i or negedge fcb_rst_ni) begin
    if (!fcb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        cnt_q <= cnt_q + CNT_ONE;
      end else if (!push && pop) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; occupancy is tracked by the pointers, and stale slots never reach an output.
  always_ff @(posedge fcb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bs_last_i, bs_data_i};
    end
  end

  // Status: done pulse, sticky error, and the per-frame success counter.
  always_ff @(posedge fcb_clk_i or negedge fcb_rst_ni) begin
    if (!fcb_rst_ni) begin
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      err_last_q     <= 1'b0;
      cnt_clr_pend_q <= 1'b0;
      word_cnt_o     <= '0;
    end else begin
      done_o     <= done_set;
      err_last_q <= err_last_d;
      // A new error wins over a simultaneous clear.
      if (err_set) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
      // The counter restarts on the first word of the next frame, not at frame end.
      if (done_set || leave_err) begin
        cnt_clr_pend_q <= 1'b1;
      end else if (push) begin
        cnt_clr_pend_q <= 1'b0;
      end
      if (push && cnt_clr_pend_q) begin
        word_cnt_o <= pop_ok ? 16'd1 : 16'd0;
      end else if (pop_ok && (word_cnt_o != 16'hFFFF)) begin
        word_cnt_o <= word_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fcb_bs_loader.sv
// tb_fcb_bs_loader: frame-level bench for fcb_bs_loader.
// The source driver and APB responder are separate processes.
// Expected writes, counts and flags come from each frame's word list and its planned error position.
module tb_fcb_bs_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] ADDR  = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bs_valid = 1'b0;
  logic [31:0] bs_data = '0;
  logic        bs_last = 1'b0;
  logic        bs_ready;
  logic [31:0] paddr, pwdata;
  logic        psel, penable, pwrite;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic        busy, done, err;
  logic        clr_drv = 1'b0, clr_resp = 1'b0, err_clr;
  logic [15:0] word_cnt;

  assign err_clr = clr_drv | clr_resp;

  fcb_bs_loader #(.FIFO_DEPTH(DEPTH), .BS_ADDR(ADDR)) dut (
    .fcb_clk_i          (clk),
    .fcb_rst_ni         (rst_n),
    .bs_valid_i         (bs_valid),
    .bs_data_i          (bs_data),
    .bs_last_i          (bs_last),
    .bs_ready_o         (bs_ready),
    .fcb_apbm_paddr_o   (paddr),
    .fcb_apbm_psel_o    (psel),
    .fcb_apbm_penable_o (penable),
    .fcb_apbm_pwrite_o  (pwrite),
    .fcb_apbm_pwdata_o  (pwdata),
    .fcb_apbm_pready_i  (pready),
    .fcb_apbm_pslverr_i (pslverr),
    .busy_o             (busy),
    .done_o             (done),
    .err_o              (err),
    .err_clr_i          (err_clr),
    .word_cnt_o         (word_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Shared frame context.
  logic [31:0] exp_q[$];
  int  xfer_idx = 0, err_idx = -1, wait_mode = 0;
  bit  clr_on_err = 1'b0, occ_chk = 1'b0, saw_full = 1'b0, exp_err = 1'b0;
  int  acc_n = 0, pop_n = 0, done_seen = 0;
  int  first_acc = -1, first_psel = -1, first_cmp = -1, last_cmp = -1;
  int  acc_cyc = 0, tgt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_wait(input int mode);
    case (mode)
      0:       return 0;
      1:       return int'($urandom_range(0, 3));
      2:       return 3;
      default: return 1 << 30;
    endcase
  endfunction

  always @(negedge clk) if (rst_n && done) done_seen++;

  // APB responder: inserts wait states, injects the planned slave error, checks each write.
  initial begin
    forever begin
      @(negedge clk);
      pready   = 1'b0;
      pslverr  = 1'b0;
      clr_resp = 1'b0;
      if (rst_n && psel) begin
        if (first_psel < 0) first_psel = cyc;
        if (!penable) begin
          check("setup_pwrite", pwrite, 1);
          check("setup_paddr", paddr, ADDR);
          acc_cyc = 0;
          tgt = pick_wait(wait_mode);
        end else if (acc_cyc >= tgt) begin
          pready = 1'b1;
          if (xfer_idx < exp_q.size()) check("pwdata", pwdata, exp_q[xfer_idx]);
          else check("extra_xfer", xfer_idx, exp_q.size());
          check("access_paddr", paddr, ADDR);
          if (xfer_idx == err_idx) begin
            pslverr = 1'b1;
            if (clr_on_err) clr_resp = 1'b1;
          end
          if (first_cmp < 0) first_cmp = cyc;
          last_cmp = cyc;
          xfer_idx++;
          pop_n++;
        end else begin
          acc_cyc++;
        end
      end
    end
  end

  // Flow-control monitor: with no error in flight, stalling the source means the queue is full.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && occ_chk && !bs_ready) begin
        check("full_occ", acc_n - pop_n, DEPTH);
        saw_full = 1'b1;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    bs_valid = 1'b1;
    bs_data  = d;
    bs_last  = l;
    while (!bs_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check("ready_tmo", bs_ready, 1);
    end else begin
      if (first_acc < 0) first_acc = cyc;
      acc_n++;
    end
    @(negedge clk);
    bs_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle", busy, 0);
  endtask

  task automatic pulse_clr();
    clr_drv = 1'b1;
    @(negedge clk);
    clr_drv = 1'b0;
    exp_err = 1'b0;
    check("err_clr", err, 0);
  endtask

  // One frame of n words; err_at < 0 means no slave error.
  task automatic run_frame(input int n, input int err_at, input int mode, input int gap_max,
                           input bit clr_same);
    logic [31:0] words[$];
    int n_xfer, done0;
    words.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
    n_xfer = (err_at >= 0) ? err_at + 1 : n;
    for (int i = 0; i < n_xfer; i++) exp_q.push_back(words[i]);
    xfer_idx   = 0;
    err_idx    = err_at;
    wait_mode  = mode;
    clr_on_err = clr_same;
    occ_chk    = (err_at < 0);
    acc_n      = 0;
    pop_n      = 0;
    first_acc  = -1;
    first_psel = -1;
    first_cmp  = -1;
    last_cmp   = -1;
    done0      = done_seen;
    for (int i = 0; i < n; i++) begin
      send_word(words[i], (i == n - 1));
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    occ_chk = 1'b0;
    if (err_at >= 0) exp_err = 1'b1;
    check("xfers", xfer_idx, n_xfer);
    check("word_cnt", word_cnt, (err_at >= 0) ? err_at : n);
    check("done_cnt", done_seen - done0, (err_at >= 0) ? 0 : 1);
    check("err", err, exp_err);
    check("psel_idle", psel, 0);
  endtask

  initial begin
    int n, e, done0;
    logic [31:0] w;

    // Reset state.
    #1;
    check("rst_ready", bs_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wcnt", word_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Three back-to-back words with zero-wait slave: writes at N+2, N+4, N+6.
    run_frame(3, -1, 0, 0, 1'b0);
    check("lat_psel", first_psel - first_acc, 1);
    check("lat_first", first_cmp - first_acc, 2);
    check("lat_three", last_cmp - first_acc, 6);

    // Eight words against a slow slave: the source must stall at full occupancy.
    saw_full = 1'b0;
    run_frame(8, -1, 2, 0, 1'b0);
    check("saw_full", saw_full, 1);

    // Slave error on word 2 of 5: rest discarded, one good write counted.
    run_frame(5, 1, 1, 1, 1'b0);
    pulse_clr();

    // Clear and error in the same cycle: error stays set.
    run_frame(2, 0, 0, 0, 1'b1);
    pulse_clr();

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      n = int'($urandom_range(1, 8));
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_frame(n, e, 1, 2, 1'b0);
      if (exp_err && ($urandom_range(0, 1) == 1)) pulse_clr();
    end

    // Reset in the middle of an ACCESS phase.
    w = $urandom;
    exp_q.delete();
    exp_q.push_back(w);
    xfer_idx  = 0;
    err_idx   = -1;
    wait_mode = 3;
    occ_chk   = 1'b0;
    send_word(w, 1'b1);
    n = 0;
    while (!(psel && penable) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_access", penable, 1);
    done0 = done_seen;
    rst_n = 1'b0;
    #1;
    check("mid_rst_psel", psel, 0);
    check("mid_rst_penable", penable, 0);
    check("mid_rst_paddr", paddr, 0);
    check("mid_rst_pwdata", pwdata, 0);
    check("mid_rst_ready", bs_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wcnt", word_cnt, 0);
    check("mid_rst_err", err, 0);
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_done_after_rst", done_seen - done0, 0);
    check("idle_after_rst", busy, 0);
    run_frame(1, -1, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
